// File: rtl/chatbot_soc_irq_pkg.sv
// Shared constants for the chatbot SoC interrupt aggregator: register map and widths.
package chatbot_soc_irq_pkg;

    localparam int unsigned MAX_SRC = 16;
    localparam int unsigned ID_W    = 4;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ADDR_W  = 3;

    localparam logic [ADDR_W-1:0] ADDR_PENDING = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_MASK    = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_EDGE    = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_ACTIVE  = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_RAW     = 3'd4;

endpackage

// File: rtl/chatbot_soc_irq_prio_enc.sv
// Lowest-index-first priority encoder; combinational valid flag and winning index.
module chatbot_soc_irq_prio_enc
    import chatbot_soc_irq_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]    req,
    output logic            valid_c,
    output logic [ID_W-1:0] id_c
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        valid_c = |req;
        id_c    = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                id_c = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/chatbot_soc_irq_ctrl.sv
// Avalon-MM interrupt aggregator: latches, masks and prioritises up to 16 sources.
// Optional input synchroniser enabled by defining CHATBOT_IRQ_SYNC_EN.
module chatbot_soc_irq_ctrl
    import chatbot_soc_irq_pkg::*;
#(
    parameter int unsigned        N_SRC      = 8,
    parameter logic [MAX_SRC-1:0] EDGE_RESET = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    input  logic [N_SRC-1:0]  irq_in,
    output logic              irq,
    output logic [ID_W-1:0]   irq_id
);

    logic [N_SRC-1:0]  raw_c;
    logic [N_SRC-1:0]  prev;
    logic [N_SRC-1:0]  pending;
    logic [N_SRC-1:0]  mask;
    logic [N_SRC-1:0]  edge_sel;
    logic [N_SRC-1:0]  edge_det_c;
    logic [N_SRC-1:0]  w1c_c;
    logic [N_SRC-1:0]  pending_nxt_c;
    logic [N_SRC-1:0]  act_c;
    logic              wr_c;
    logic              enc_valid_c;
    logic [ID_W-1:0]   enc_id_c;
    logic [DATA_W-1:0] rd_mux_c;
    logic              unused_wdata;

    assign unused_wdata = ^writedata;

`ifdef CHATBOT_IRQ_SYNC_EN
    logic [N_SRC-1:0] sync_q1;
    logic [N_SRC-1:0] sync_q2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_in;
            sync_q2 <= sync_q1;
        end
    end

    assign raw_c = sync_q2;
`else
    assign raw_c = irq_in;
`endif

    assign wr_c       = chipselect & ~write_n;
    assign w1c_c      = (wr_c && address == ADDR_PENDING) ? writedata[N_SRC-1:0] : '0;
    assign edge_det_c = raw_c & ~prev;

    // Edge sources: a new edge beats a same-cycle clear. Level sources follow raw.
    assign pending_nxt_c = (edge_sel & (edge_det_c | (pending & ~w1c_c)))
                         | (~edge_sel & raw_c);

    assign act_c = pending & mask;

    chatbot_soc_irq_prio_enc #(
        .N (N_SRC)
    ) u_prio_enc (
        .req     (act_c),
        .valid_c (enc_valid_c),
        .id_c    (enc_id_c)
    );

    always_comb begin
        rd_mux_c = '0;
        case (address)
            ADDR_PENDING: rd_mux_c = DATA_W'(pending);
            ADDR_MASK:    rd_mux_c = DATA_W'(mask);
            ADDR_EDGE:    rd_mux_c = DATA_W'(edge_sel);
            ADDR_ACTIVE:  rd_mux_c = {enc_valid_c, 11'd0, enc_id_c};
            ADDR_RAW:     rd_mux_c = DATA_W'(raw_c);
            default:      rd_mux_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev     <= '0;
            pending  <= '0;
            mask     <= '0;
            edge_sel <= EDGE_RESET[N_SRC-1:0];
            readdata <= '0;
            irq      <= 1'b0;
            irq_id   <= '0;
        end else begin
            prev     <= raw_c;
            pending  <= pending_nxt_c;
            readdata <= rd_mux_c;
            irq      <= enc_valid_c;
            irq_id   <= enc_id_c;
            if (wr_c && address == ADDR_MASK) begin
                mask <= writedata[N_SRC-1:0];
            end
            if (wr_c && address == ADDR_EDGE) begin
                edge_sel <= writedata[N_SRC-1:0];
            end
        end
    end

endmodule

// File: tb/tb_chatbot_soc_irq_ctrl.sv
// Directed self-checking bench for chatbot_soc_irq_ctrl (default build, N_SRC=8).
module tb_chatbot_soc_irq_ctrl;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [7:0]  irq_in;
    logic        irq;
    logic [3:0]  irq_id;

    int checks;
    int failures;

    chatbot_soc_irq_ctrl #(
        .N_SRC      (8),
        .EDGE_RESET (16'h0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .irq        (irq),
        .irq_id     (irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [15:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'h0000;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [15:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (readdata !== 16'h0000 || irq !== 1'b0 || irq_id !== 4'd0) begin
            failures++;
            $display("FAIL reset_outputs: readdata=%h irq=%b irq_id=%0d, want 0000/0/0", readdata, irq, irq_id);
        end
        reg_read(3'd1, rd);
        checks++;
        if (rd !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mask: got %h want 0000", rd);
        end
        reg_read(3'd2, rd);
        checks++;
        if (rd !== 16'h0000) begin
            failures++;
            $display("FAIL reset_edge_sel: got %h want 0000", rd);
        end
    endtask

    task automatic test_raw_unused();
        logic [15:0] rd;
        irq_in = 8'hA5;
        reg_read(3'd4, rd);
        checks++;
        if (rd !== 16'h00A5) begin
            failures++;
            $display("FAIL raw_read: got %h want 00a5", rd);
        end
        irq_in = 8'h00;
        reg_write(3'd5, 16'hFFFF);
        reg_read(3'd5, rd);
        checks++;
        if (rd !== 16'h0000) begin
            failures++;
            $display("FAIL addr5_read: got %h want 0000", rd);
        end
        reg_write(3'd1, 16'hFF3C);
        reg_read(3'd1, rd);
        checks++;
        if (rd !== 16'h003C) begin
            failures++;
            $display("FAIL mask_upper_bits: got %h want 003c", rd);
        end
        tick();
    endtask

    task automatic test_edge_basic();
        logic [15:0] rd;
        reg_write(3'd1, 16'h0001);
        reg_write(3'd2, 16'h0001);
        irq_in = 8'h01;
        tick();
        irq_in = 8'h00;
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL edge_latency_early: irq=%b want 0", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b1 || irq_id !== 4'd0) begin
            failures++;
            $display("FAIL edge_irq: irq=%b irq_id=%0d want 1/0", irq, irq_id);
        end
        reg_read(3'd0, rd);
        checks++;
        if (rd !== 16'h0001) begin
            failures++;
            $display("FAIL edge_pending: got %h want 0001", rd);
        end
        reg_write(3'd0, 16'h0001);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL w1c_latency: irq=%b want 1 right after clear edge", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL w1c_irq_low: irq=%b want 0", irq);
        end
    endtask

    task automatic test_priority();
        logic [15:0] rd;
        reg_write(3'd1, 16'h00FF);
        reg_write(3'd2, 16'h00FF);
        irq_in = 8'h24;
        tick();
        irq_in = 8'h00;
        tick();
        checks++;
        if (irq !== 1'b1 || irq_id !== 4'd2) begin
            failures++;
            $display("FAIL prio_first: irq=%b irq_id=%0d want 1/2", irq, irq_id);
        end
        reg_read(3'd3, rd);
        checks++;
        if (rd !== 16'h8002) begin
            failures++;
            $display("FAIL prio_active_first: got %h want 8002", rd);
        end
        reg_write(3'd0, 16'h0004);
        tick();
        checks++;
        if (irq !== 1'b1 || irq_id !== 4'd5) begin
            failures++;
            $display("FAIL prio_second: irq=%b irq_id=%0d want 1/5", irq, irq_id);
        end
        reg_read(3'd3, rd);
        checks++;
        if (rd !== 16'h8005) begin
            failures++;
            $display("FAIL prio_active_second: got %h want 8005", rd);
        end
        reg_write(3'd0, 16'h0020);
        tick();
        checks++;
        if (irq !== 1'b0 || irq_id !== 4'd0) begin
            failures++;
            $display("FAIL prio_cleared: irq=%b irq_id=%0d want 0/0", irq, irq_id);
        end
        reg_read(3'd3, rd);
        checks++;
        if (rd !== 16'h0000) begin
            failures++;
            $display("FAIL prio_active_cleared: got %h want 0000", rd);
        end
    endtask

    task automatic test_set_wins();
        logic [15:0] rd;
        irq_in = 8'h08;
        tick();
        irq_in = 8'h00;
        tick();
        irq_in     = 8'h08;
        address    = 3'd0;
        writedata  = 16'h0008;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        irq_in     = 8'h00;
        reg_read(3'd0, rd);
        checks++;
        if (rd !== 16'h0008) begin
            failures++;
            $display("FAIL set_wins: pending=%h want 0008", rd);
        end
        reg_write(3'd0, 16'h0008);
        reg_read(3'd0, rd);
        checks++;
        if (rd !== 16'h0000) begin
            failures++;
            $display("FAIL set_wins_cleanup: pending=%h want 0000", rd);
        end
    endtask

    task automatic test_level();
        logic [15:0] rd;
        reg_write(3'd2, 16'h00FD);
        reg_write(3'd1, 16'h0002);
        irq_in = 8'h02;
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (irq !== 1'b1 || irq_id !== 4'd1) begin
                failures++;
                $display("FAIL level_hold[%0d]: irq=%b irq_id=%0d want 1/1", i, irq, irq_id);
            end
            tick();
        end
        reg_write(3'd0, 16'h0002);
        tick();
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL level_w1c_ignored: irq=%b want 1", irq);
        end
        reg_read(3'd0, rd);
        checks++;
        if (rd !== 16'h0002) begin
            failures++;
            $display("FAIL level_pending: got %h want 0002", rd);
        end
        irq_in = 8'h00;
        tick();
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL level_drop_early: irq=%b want 1", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL level_drop: irq=%b want 0", irq);
        end
    endtask

    task automatic test_masked_then_reset();
        logic [15:0] rd;
        reg_write(3'd1, 16'h0000);
        reg_write(3'd2, 16'h00FF);
        irq_in = 8'h10;
        tick();
        irq_in = 8'h00;
        tick();
        reg_read(3'd0, rd);
        checks++;
        if (rd !== 16'h0010 || irq !== 1'b0) begin
            failures++;
            $display("FAIL masked_pending: pending=%h irq=%b want 0010/0", rd, irq);
        end
        reg_write(3'd1, 16'h0010);
        tick();
        checks++;
        if (irq !== 1'b1 || irq_id !== 4'd4) begin
            failures++;
            $display("FAIL unmask_irq: irq=%b irq_id=%0d want 1/4", irq, irq_id);
        end
        address = 3'd1;
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (irq !== 1'b0 || irq_id !== 4'd0 || readdata !== 16'h0000) begin
            failures++;
            $display("FAIL midrun_reset: irq=%b irq_id=%0d readdata=%h want 0/0/0000", irq, irq_id, readdata);
        end
        reset = 1'b0;
        reg_read(3'd0, rd);
        checks++;
        if (rd !== 16'h0000) begin
            failures++;
            $display("FAIL reset_pending: got %h want 0000", rd);
        end
        reg_read(3'd1, rd);
        checks++;
        if (rd !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mask_after: got %h want 0000", rd);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'h0000;
        irq_in     = 8'h00;
        test_reset();
        test_raw_unused();
        test_edge_basic();
        test_priority();
        test_set_wins();
        test_level();
        test_masked_then_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
